// File: rtl/regblock_pkg.sv
// Shared types and helpers for the regblock command front-end.
package regblock_pkg;

    localparam int unsigned RbWidth = 32;

    typedef enum logic [0:0] {
        StInit = 1'b0,
        StRun  = 1'b1
    } state_e;

    typedef struct packed {
        logic               write;
        logic [RbWidth-1:0] data;
    } rsp_t;

    function automatic int unsigned idx_width(input int unsigned nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

endpackage

// File: rtl/regblock_rsp_fifo.sv
// Synchronous response FIFO; head entry is presented directly, no bypass path.
module regblock_rsp_fifo
    import regblock_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type entry_t = rsp_t
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   push_i,
    input  entry_t wdata_i,
    input  logic   pop_i,
    output entry_t rdata_o,
    output logic   empty_o,
    output logic   full_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [PtrW:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW:0] rd_ptr_q, rd_ptr_d;
    entry_t        mem_q [DEPTH];
    logic          do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                     (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    assign rdata_o = mem_q[rd_ptr_q[PtrW-1:0]];

    // A pop against an empty FIFO is dropped even if a push lands this cycle.
    assign do_pop = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q[PtrW-1:0]] <= wdata_i;
    end

    push_not_full_a: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full_o));

endmodule

// File: rtl/regblock_cmd_ctrl.sv
// Command front-end for regblock: clears all registers after reset, then issues commands
// through a two-stage pipeline and returns in-order responses under credit flow control.
module regblock_cmd_ctrl
    import regblock_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned NREGS     = 2,
    parameter int unsigned RSP_DEPTH = 4,
    localparam int unsigned IdxW     = idx_width(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [IdxW-1:0]  cmd_idx,
    input  logic [WIDTH-1:0] cmd_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_write,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rb_en,
    output logic [IdxW-1:0]  rb_wr_index,
    output logic [WIDTH-1:0] rb_d,
    output logic [IdxW-1:0]  rb_rd_index,
    input  logic [WIDTH-1:0] rb_q
);

    localparam int unsigned CredW = $clog2(RSP_DEPTH + 1);

    typedef struct packed {
        logic             write;
        logic [WIDTH-1:0] data;
    } rsp_entry_t;

    state_e           state_q, state_d;
    logic [IdxW-1:0]  init_cnt_q, init_cnt_d;
    logic [CredW-1:0] credits_q, credits_d;
    logic             rb_en_q, rb_en_d;
    logic [IdxW-1:0]  rb_wr_index_q, rb_wr_index_d;
    logic [WIDTH-1:0] rb_d_q, rb_d_d;
    logic [IdxW-1:0]  rb_rd_index_q, rb_rd_index_d;
    logic             s1_valid_q, s1_valid_d, s1_write_q, s1_write_d;
    logic             s2_valid_q, s2_valid_d, s2_write_q, s2_write_d;

    logic       accept, pop, fifo_empty, fifo_full;
    rsp_entry_t push_entry, head_entry;

    assign cmd_ready = (state_q == StRun) && (credits_q != '0);
    assign accept    = cmd_valid && cmd_ready;
    assign rsp_valid = !fifo_empty;
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_write = head_entry.write;
    assign rsp_data  = head_entry.data;

    assign rb_en       = rb_en_q;
    assign rb_wr_index = rb_wr_index_q;
    assign rb_d        = rb_d_q;
    assign rb_rd_index = rb_rd_index_q;

    // rb_q for an S2 read is valid now: its index was driven from S1 last cycle.
    assign push_entry.write = s2_write_q;
    assign push_entry.data  = s2_write_q ? '0 : rb_q;

    always_comb begin
        state_d       = state_q;
        init_cnt_d    = init_cnt_q;
        rb_en_d       = 1'b0;
        rb_wr_index_d = rb_wr_index_q;
        rb_d_d        = rb_d_q;
        rb_rd_index_d = rb_rd_index_q;
        s1_valid_d    = accept;
        s1_write_d    = cmd_write;
        s2_valid_d    = s1_valid_q;
        s2_write_d    = s1_write_q;

        case (state_q)
            StInit: begin
                rb_en_d       = 1'b1;
                rb_wr_index_d = init_cnt_q;
                rb_d_d        = '0;
                if (init_cnt_q == IdxW'(NREGS - 1)) begin
                    state_d = StRun;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            StRun: begin
                if (accept) begin
                    if (cmd_write) begin
                        rb_en_d       = 1'b1;
                        rb_wr_index_d = cmd_idx;
                        rb_d_d        = cmd_wdata;
                    end else begin
                        rb_rd_index_d = cmd_idx;
                    end
                end
            end
            default: state_d = StInit;
        endcase
    end

    // One credit per outstanding command, covering both pipeline stages and the FIFO.
    always_comb begin
        credits_d = credits_q;
        case ({accept, pop})
            2'b10:   credits_d = credits_q - 1'b1;
            2'b01:   credits_d = credits_q + 1'b1;
            default: credits_d = credits_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StInit;
            init_cnt_q    <= '0;
            credits_q     <= CredW'(RSP_DEPTH);
            rb_en_q       <= 1'b0;
            rb_wr_index_q <= '0;
            rb_d_q        <= '0;
            rb_rd_index_q <= '0;
            s1_valid_q    <= 1'b0;
            s1_write_q    <= 1'b0;
            s2_valid_q    <= 1'b0;
            s2_write_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            init_cnt_q    <= init_cnt_d;
            credits_q     <= credits_d;
            rb_en_q       <= rb_en_d;
            rb_wr_index_q <= rb_wr_index_d;
            rb_d_q        <= rb_d_d;
            rb_rd_index_q <= rb_rd_index_d;
            s1_valid_q    <= s1_valid_d;
            s1_write_q    <= s1_write_d;
            s2_valid_q    <= s2_valid_d;
            s2_write_q    <= s2_write_d;
        end
    end

    regblock_rsp_fifo #(
        .DEPTH   (RSP_DEPTH),
        .entry_t (rsp_entry_t)
    ) u_rsp_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (s2_valid_q),
        .wdata_i (push_entry),
        .pop_i   (pop),
        .rdata_o (head_entry),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    // Credits guarantee the FIFO never fills past capacity; full is only observed by the assertion.
    logic unused_full;
    assign unused_full = fifo_full;

endmodule
